seq_detect_counter: RTL and testbench

// - Parametrised serial pattern detector with detection counter; next-generation serial-stream FSM block.
// - Generalises the fixed-pattern detector: pattern width and counter width are parameters.
// - Pattern is loaded at run time.
// - Adds an overlap/non-overlap mode, an input-valid qualifier, a saturating count and a synchronous clear.
// - Sits between a serial bit source and a status/statistics register bank.

---
 rtl/seq_detect_pkg.sv | 21 ++
 rtl/sat_counter.sv | 39 +++
 rtl/seq_detect_counter.sv | 108 ++++++++++
 tb/tb_seq_detect_counter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
//------------------------------------------------------------------------------
// Module  : seq_detect_pkg
// Brief   : Shared state encoding and mode constants for the serial detector.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package seq_detect_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        FILLING = 2'b01,
        ARMED   = 2'b10
    } state_t;

    localparam logic OVL_ON  = 1'b1;
    localparam logic OVL_OFF = 1'b0;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
//------------------------------------------------------------------------------
// Module  : sat_counter
// Brief   : Saturating event counter with sticky saturation flag.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module sat_counter #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
            // sat rises on the very edge the counter lands on all-ones
            if (count == (CNT_MAX - 1'b1)) begin
                sat <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_detect_counter.sv
//------------------------------------------------------------------------------
// Module  : seq_detect_counter
// Brief   : Run-time loadable serial pattern detector with saturating count.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_detect_counter #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x,
    input  logic             x_valid,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] users_count,
    output logic             sat
);

    import seq_detect_pkg::*;

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pattern_q;
    logic              overlap_q;
    logic [PAT_W-1:0]  hist_q;
    logic [PAT_W-1:0]  hist_d;
    logic [FILL_W-1:0] fill_q;
    logic [FILL_W-1:0] fill_d;
    state_t            state_q;
    state_t            state_d;
    logic              y_q;

    logic              accept;
    logic              can_match;
    logic              match;
    logic [PAT_W-1:0]  shifted;

    // clr and cfg_load both swallow the bit presented in their cycle
    assign accept    = x_valid && !clr && !cfg_load;
    assign shifted   = {hist_q[PAT_W-2:0], x};
    assign can_match = (state_q == ARMED) ||
                       ((state_q == FILLING) && (fill_q == FILL_LAST));
    assign match     = accept && can_match && (shifted == pattern_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            fill_q    <= '0;
            hist_q    <= '0;
            y_q       <= 1'b0;
            pattern_q <= '0;
            overlap_q <= OVL_ON;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            hist_q  <= hist_d;
            y_q     <= match;
            if (cfg_load && !clr) begin
                pattern_q <= cfg_pattern;
                overlap_q <= cfg_overlap;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        hist_d  = hist_q;
        if (clr || cfg_load) begin
            state_d = EMPTY;
            fill_d  = '0;
            hist_d  = '0;
        end else if (x_valid) begin
            hist_d = shifted;
            if (match && (overlap_q == OVL_OFF)) begin
                state_d = EMPTY;
                fill_d  = '0;
            end else begin
                fill_d  = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
                state_d = (fill_d == FILL_FULL) ? ARMED : FILLING;
            end
        end
    end

    assign y = y_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (match),
        .clr   (clr),
        .count (users_count),
        .sat   (sat)
    );

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_counter.sv
//------------------------------------------------------------------------------
// Module  : tb_seq_detect_counter
// Brief   : Scoreboard bench for seq_detect_counter (CNT_W=10 and CNT_W=3 copies).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       x = 1'b0;
    logic       x_valid = 1'b0;
    logic       cfg_load = 1'b0;
    logic [3:0] cfg_pattern = 4'b0000;
    logic       cfg_overlap = 1'b1;
    logic       clr = 1'b0;

    logic       y_a;
    logic [9:0] cnt_a;
    logic       sat_a;
    logic       y_b;
    logic [2:0] cnt_b;
    logic       sat_b;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_a  = 0;
    int exp_b  = 0;

    logic [10:0] q_a[$];
    logic [3:0]  q_b[$];

    always #5 clk = ~clk;

    seq_detect_counter #(.PAT_W(4), .CNT_W(10)) u_dut_a (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr(clr),
        .y(y_a), .users_count(cnt_a), .sat(sat_a)
    );

    seq_detect_counter #(.PAT_W(4), .CNT_W(3)) u_dut_b (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_overlap(cfg_overlap), .clr(clr),
        .y(y_b), .users_count(cnt_b), .sat(sat_b)
    );

    // Monitor: every y pulse consumes one expected {sat,count} entry.
    always @(negedge clk) begin
        logic [10:0] ea;
        logic [3:0]  eb;
        if (y_a) begin
            n_cmp++;
            if (q_a.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_a: got unexpected y with count %0d, required no pulse", cnt_a);
            end else begin
                ea = q_a.pop_front();
                if ({sat_a, cnt_a} !== ea) begin
                    n_fail++;
                    $display("FAIL pulse_a: got sat=%0b count=%0d required sat=%0b count=%0d",
                             sat_a, cnt_a, ea[10], ea[9:0]);
                end
            end
        end
        if (y_b) begin
            n_cmp++;
            if (q_b.size() == 0) begin
                n_fail++;
                $display("FAIL pulse_b: got unexpected y with count %0d, required no pulse", cnt_b);
            end else begin
                eb = q_b.pop_front();
                if ({sat_b, cnt_b} !== eb) begin
                    n_fail++;
                    $display("FAIL pulse_b: got sat=%0b count=%0d required sat=%0b count=%0d",
                             sat_b, cnt_b, eb[3], eb[2:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic push_match();
        if (exp_a < 1023) exp_a++;
        if (exp_b < 7) exp_b++;
        q_a.push_back({(exp_a == 1023), 10'(exp_a)});
        q_b.push_back({(exp_b == 7), 3'(exp_b)});
    endtask

    task automatic drive(input logic b, input logic v, input logic ld, input logic c);
        @(posedge clk);
        #1;
        x        = b;
        x_valid  = v;
        cfg_load = ld;
        clr      = c;
    endtask

    task automatic bit_in(input logic b, input logic v, input bit m);
        drive(b, v, 1'b0, 1'b0);
        if (m) push_match();
    endtask

    task automatic load(input logic [3:0] p, input logic o);
        cfg_pattern = p;
        cfg_overlap = o;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic do_clr();
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        exp_a = 0;
        exp_b = 0;
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("pending_a", q_a.size(), 0);
        check("pending_b", q_b.size(), 0);
    endtask

    initial begin
        logic [6:0] s7;
        s7 = 7'b1011011;

        #3;
        check("reset_y", y_a, 0);
        check("reset_count", cnt_a, 0);
        check("reset_sat", sat_b, 0);
        @(negedge clk);
        rst = 1'b1;

        // Overlapping: 1011011 -> matches on bits 4 and 7
        load(4'b1011, 1'b1);
        do_clr();
        for (int i = 0; i < 7; i++) bit_in(s7[6-i], 1'b1, (i == 3) || (i == 6));
        settle();
        check("ovl_count", cnt_a, 2);

        // Non-overlapping: same stream -> single match on bit 4
        load(4'b1011, 1'b0);
        do_clr();
        for (int i = 0; i < 7; i++) bit_in(s7[6-i], 1'b1, i == 3);
        settle();
        check("novl_count", cnt_a, 1);

        // Long alternating run, pattern 1010
        load(4'b1010, 1'b1);
        do_clr();
        for (int i = 1; i <= 100; i++) bit_in(i[0] ? 1'b1 : 1'b0, 1'b1, (i >= 4) && !i[0]);
        settle();
        check("long_ovl_count", cnt_a, 49);
        check("long_ovl_sat_b", sat_b, 1);

        load(4'b1010, 1'b0);
        do_clr();
        for (int i = 1; i <= 100; i++) bit_in(i[0] ? 1'b1 : 1'b0, 1'b1, (i % 4) == 0);
        settle();
        check("long_novl_count", cnt_a, 25);

        // Gaps: invalid cycles carry garbage x and must not disturb history
        load(4'b1011, 1'b1);
        do_clr();
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b0, 1'b1, 0);
        for (int i = 0; i < 3; i++) bit_in(1'b1, 1'b0, 0);
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b1, 1'b1, 1);
        settle();
        check("gap_count", cnt_a, 1);

        // Saturation on the 3-bit counter: 9 matches
        load(4'b1011, 1'b1);
        do_clr();
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b0, 1'b1, 0);
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b1, 1'b1, 1);
        for (int i = 0; i < 8; i++) begin
            bit_in(1'b0, 1'b1, 0);
            bit_in(1'b1, 1'b1, 0);
            bit_in(1'b1, 1'b1, 1);
        end
        settle();
        check("sat_count_b", cnt_b, 7);
        check("sat_flag_b", sat_b, 1);
        check("sat_count_a", cnt_a, 9);
        check("sat_flag_a", sat_a, 0);
        do_clr();
        settle();
        check("clr_count_b", cnt_b, 0);
        check("clr_sat_b", sat_b, 0);

        // Asynchronous reset in mid-stream
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b0, 1'b1, 0);
        bit_in(1'b1, 1'b1, 1);
        // the third bit above completes nothing; its flag is undone below
        void'(q_a.pop_back());
        void'(q_b.pop_back());
        exp_a = 0;
        exp_b = 0;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        rst     = 1'b0;
        #2;
        check("async_rst_y", y_a, 0);
        check("async_rst_hold", cnt_a, 0);
        @(negedge clk);
        rst = 1'b1;
        bit_in(1'b1, 1'b1, 0);
        settle();
        check("rst_mid_count", cnt_a, 0);

        // clr arriving with the completing bit
        load(4'b1011, 1'b1);
        bit_in(1'b1, 1'b1, 0);
        bit_in(1'b0, 1'b1, 0);
        bit_in(1'b1, 1'b1, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1);
        settle();
        check("clr_bit_count", cnt_a, 0);
        check("clr_bit_sat", sat_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
